// File: rtl/cake_eat_ctrl.sv
// Cake life-cycle controller: places, validates, detects eats, keeps BCD score and regenerates.
// Optional CAKE_BONUS_EN: eats within BONUS_STEPS steps of placement score +2.
module cake_eat_ctrl #(
  parameter logic [11:0] X_MIN       = 12'd16,
  parameter logic [11:0] X_MAX       = 12'd624,
  parameter logic [11:0] Y_MIN       = 12'd16,
  parameter logic [11:0] Y_MAX       = 12'd464,
  parameter int          SETTLE_CYC  = 2,
  parameter int          MAX_RETRY   = 8,
  parameter int          BONUS_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [11:0] head_x,
  input  logic [11:0] head_y,
  input  logic [11:0] box_x,
  input  logic [11:0] box_y,
  output logic        drive,
  output logic [11:0] cake_x,
  output logic [11:0] cake_y,
  output logic        cake_valid,
  output logic        grow,
  output logic [15:0] score,
  output logic        busy
);

  typedef enum logic [2:0] {ST_BOOT, ST_IDLE, ST_REQ, ST_WAIT, ST_CHECK} state_t;

  state_t      state, state_nxt;
  logic [3:0]  settle_cnt, settle_nxt;
  logic [3:0]  retry_cnt, retry_nxt;
  logic [11:0] head_x_lat, head_y_lat;
  logic [11:0] cmp_x, cmp_y;
  logic [11:0] cake_x_nxt, cake_y_nxt;
  logic [15:0] score_nxt, score_inc1, score_inc2;
  logic        valid_nxt, drive_nxt, grow_nxt, busy_nxt;
  logic        eat, box_ok, add_two;

  // Saturating 4-digit BCD increment; 9999 holds.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) return v;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A step in the CHECK cycle must be compared against the newest head.
  assign cmp_x  = step ? head_x : head_x_lat;
  assign cmp_y  = step ? head_y : head_y_lat;
  assign box_ok = (box_x >= X_MIN) && (box_x <= X_MAX) &&
                  (box_y >= Y_MIN) && (box_y <= Y_MAX) &&
                  !((box_x == cmp_x) && (box_y == cmp_y));
  assign eat    = (state == ST_IDLE) && step && cake_valid &&
                  (head_x == cake_x) && (head_y == cake_y);

  assign score_inc1 = bcd_inc(score);
  assign score_inc2 = bcd_inc(score_inc1);

`ifdef CAKE_BONUS_EN
  logic [5:0] step_cnt;

  assign add_two = ({26'd0, step_cnt} < 32'(BONUS_STEPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= 6'd0;
    end else if (valid_nxt && !cake_valid) begin
      step_cnt <= 6'd0;
    end else if ((state == ST_IDLE) && step && (step_cnt != 6'd63)) begin
      step_cnt <= step_cnt + 6'd1;
    end
  end
`else
  assign add_two = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    retry_nxt  = retry_cnt;
    cake_x_nxt = cake_x;
    cake_y_nxt = cake_y;
    valid_nxt  = cake_valid;
    score_nxt  = score;
    drive_nxt  = 1'b0;
    grow_nxt   = 1'b0;
    case (state)
      ST_BOOT: begin
        state_nxt = ST_REQ;
        drive_nxt = 1'b1;
      end
      ST_IDLE: begin
        if (eat) begin
          state_nxt = ST_REQ;
          drive_nxt = 1'b1;
          grow_nxt  = 1'b1;
          valid_nxt = 1'b0;
          score_nxt = add_two ? score_inc2 : score_inc1;
        end
      end
      ST_REQ: begin
        settle_nxt = 4'(SETTLE_CYC);
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        settle_nxt = settle_cnt - 4'd1;
        if (settle_cnt <= 4'd1) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (box_ok) begin
          cake_x_nxt = box_x;
          cake_y_nxt = box_y;
          valid_nxt  = 1'b1;
          retry_nxt  = 4'd0;
          state_nxt  = ST_IDLE;
        end else if (retry_cnt < 4'(MAX_RETRY - 1)) begin
          retry_nxt = retry_cnt + 4'd1;
          drive_nxt = 1'b1;
          state_nxt = ST_REQ;
        end else begin
          cake_x_nxt = X_MIN;
          cake_y_nxt = Y_MIN;
          valid_nxt  = 1'b1;
          retry_nxt  = 4'd0;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      settle_cnt <= 4'd0;
      retry_cnt  <= 4'd0;
      head_x_lat <= 12'd0;
      head_y_lat <= 12'd0;
      cake_x     <= 12'd0;
      cake_y     <= 12'd0;
      cake_valid <= 1'b0;
      score      <= 16'h0000;
      drive      <= 1'b0;
      grow       <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      retry_cnt  <= retry_nxt;
      if (step) begin
        head_x_lat <= head_x;
        head_y_lat <= head_y;
      end
      cake_x     <= cake_x_nxt;
      cake_y     <= cake_y_nxt;
      cake_valid <= valid_nxt;
      score      <= score_nxt;
      drive      <= drive_nxt;
      grow       <= grow_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_cake_eat_ctrl.sv
// Randomized bench for cake_eat_ctrl with a cycle-counting reference model and literal pins.
module tb_cake_eat_ctrl;

  localparam int SETTLE    = 2;
  localparam int MAX_RETRY = 8;
  localparam int BONUS     = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic [11:0] head_x = 12'd0, head_y = 12'd0;
  logic [11:0] box_x = 12'd0, box_y = 12'd0;
  logic        drive, cake_valid, grow, busy;
  logic [11:0] cake_x, cake_y;
  logic [15:0] score;

  cake_eat_ctrl dut (
    .clk(clk), .rst_n(rst_n), .step(step), .head_x(head_x), .head_y(head_y),
    .box_x(box_x), .box_y(box_y), .drive(drive), .cake_x(cake_x), .cake_y(cake_y),
    .cake_valid(cake_valid), .grow(grow), .score(score), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_wait, m_tries, m_score, m_steps;
  bit          m_boot, m_valid, m_drive, m_grow, m_busy;
  logic [11:0] m_hx, m_hy, m_cx, m_cy;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_wait = -1; m_tries = 0; m_score = 0; m_steps = 0;
    m_boot = 1; m_valid = 0; m_drive = 0; m_grow = 0; m_busy = 1;
    m_hx = 0; m_hy = 0; m_cx = 0; m_cy = 0;
  endtask

  task automatic model_tick();
    logic [11:0] nhx, nhy;
    bit ok;
    int inc;
    nhx = step ? head_x : m_hx;
    nhy = step ? head_y : m_hy;
    m_drive = 0;
    m_grow  = 0;
    if (m_boot) begin
      m_boot = 0; m_drive = 1; m_wait = SETTLE + 1;
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (m_wait == 0) begin
      ok = (box_x >= 16) && (box_x <= 624) && (box_y >= 16) && (box_y <= 464) &&
           !((box_x == nhx) && (box_y == nhy));
      if (ok) begin
        m_cx = box_x; m_cy = box_y; m_valid = 1; m_tries = 0; m_wait = -1; m_steps = 0;
      end else if (m_tries < MAX_RETRY - 1) begin
        m_tries++; m_drive = 1; m_wait = SETTLE + 1;
      end else begin
        m_cx = 16; m_cy = 16; m_valid = 1; m_tries = 0; m_wait = -1; m_steps = 0;
      end
    end else begin
      if (step && m_valid && head_x == m_cx && head_y == m_cy) begin
        inc = 1;
`ifdef CAKE_BONUS_EN
        if (m_steps < BONUS) inc = 2;
`endif
        m_score = (m_score + inc > 9999) ? 9999 : m_score + inc;
        m_grow = 1; m_drive = 1; m_valid = 0; m_wait = SETTLE + 1;
      end
      if (step && m_steps < 63) m_steps++;
    end
    m_hx = nhx; m_hy = nhy;
    m_busy = (m_wait >= 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_tick();
    end
  end

  // ---------------- every-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("drive", drive, m_drive);
      chk("grow", grow, m_grow);
      chk("cake_valid", cake_valid, m_valid);
      chk("cake_x", cake_x, m_cx);
      chk("cake_y", cake_y, m_cy);
      chk("score", score, to_bcd(m_score));
      chk("busy", busy, m_busy);
    end
  end

  // ---------------- generator emulation ----------------
  int          mode = 0;           // 0 hold, 1 scripted list, 2 random
  logic [11:0] box_hold_x = 12'd100, box_hold_y = 12'd200;
  logic [11:0] gen_x[4], gen_y[4];
  int          gen_n = 1, gen_base = 0;
  int          drv_cnt = 0;

  initial forever begin
    int k, r;
    @(negedge clk);
    if (drive) begin
      if (mode == 1) begin
        k = drv_cnt - gen_base;
        if (k >= gen_n) k = gen_n - 1;
        box_x = gen_x[k];
        box_y = gen_y[k];
      end
      drv_cnt++;
    end
    if (mode == 0) begin
      box_x = box_hold_x;
      box_y = box_hold_y;
    end else if (mode == 2) begin
      r = $urandom_range(0, 7);
      if (r < 2) begin
        box_x = 12'($urandom_range(625, 4095));
        box_y = 12'($urandom_range(0, 4095));
      end else if (r == 2) begin
        box_x = head_x;
        box_y = head_y;
      end else begin
        box_x = 12'($urandom_range(16, 624));
        box_y = 12'($urandom_range(16, 464));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_valid();
    int n = 0;
    while (!cake_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid_timeout", cake_valid, 1'b1);
  endtask

  task automatic do_eat();
    logic [11:0] x;
    wait_valid();
    x = 12'($urandom_range(16, 624));
    if (x == cake_x) x = (cake_x == 12'd16) ? 12'd17 : 12'd16;
    box_hold_x = x;
    box_hold_y = 12'($urandom_range(16, 464));
    head_x = cake_x;
    head_y = cake_y;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic do_step(input logic [11:0] x, input logic [11:0] y);
    head_x = x; head_y = y; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
  endtask

  task automatic boot_check(input logic [11:0] ex, input logic [11:0] ey);
    int d0 = drv_cnt;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) chk("boot_drive", drive, 1'b1);
      if (i == 4) chk("boot_valid_late", cake_valid, 1'b0);
      chk("boot_grow", grow, 1'b0);
    end
    chk("boot_valid", cake_valid, 1'b1);
    chk("boot_x", cake_x, ex);
    chk("boot_y", cake_y, ey);
    chk("boot_score", score, 16'h0000);
    chk("boot_drives", drv_cnt - d0, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    logic [15:0] e1, e2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_drive", drive, 1'b0);
    chk("rst_grow", grow, 1'b0);
    chk("rst_valid", cake_valid, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_score", score, 16'h0000);
    chk("rst_cake", {cake_x, cake_y}, 24'd0);
    @(negedge clk);
    rst_n = 1'b1;
    boot_check(12'd100, 12'd200);

    // eat at (100,200), regenerate to (400,400)
    box_hold_x = 12'd400; box_hold_y = 12'd400;
    head_x = 12'd100; head_y = 12'd200; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("eat_grow", grow, 1'b1);
    chk("eat_drive", drive, 1'b1);
    chk("eat_valid", cake_valid, 1'b0);
`ifdef CAKE_BONUS_EN
    chk("eat_score", score, 16'h0002);
`else
    chk("eat_score", score, 16'h0001);
`endif
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk("eat_valid_low", cake_valid, 1'b0);
    end
    @(negedge clk);
    chk("eat_valid_back", cake_valid, 1'b1);
    chk("eat_new_cake", {cake_x, cake_y}, {12'd400, 12'd400});

    // two out-of-range candidates then a good one
    gen_x[0] = 0; gen_y[0] = 0; gen_x[1] = 0; gen_y[1] = 0;
    gen_x[2] = 300; gen_y[2] = 300; gen_n = 3;
    gen_base = drv_cnt; d0 = drv_cnt; mode = 1;
    do_eat();
    wait_valid();
    chk("retry_drives", drv_cnt - d0, 3);
    chk("retry_cake", {cake_x, cake_y}, {12'd300, 12'd300});

    // generator stuck out of range: fallback placement
    mode = 0; box_hold_x = 12'd700; box_hold_y = 12'd10;
    d0 = drv_cnt;
    head_x = cake_x; head_y = cake_y; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_valid();
    chk("fallback_drives", drv_cnt - d0, 8);
    chk("fallback_cake", {cake_x, cake_y}, {12'd16, 12'd16});

    // candidate equal to head is rejected
    gen_x[0] = 16; gen_y[0] = 16; gen_x[1] = 200; gen_y[1] = 100; gen_n = 2;
    gen_base = drv_cnt; d0 = drv_cnt; mode = 1;
    do_eat();
    wait_valid();
    chk("head_rej_drives", drv_cnt - d0, 2);
    chk("head_rej_cake", {cake_x, cake_y}, {12'd200, 12'd100});
`ifdef CAKE_BONUS_EN
    chk("score_after_4", score, 16'h0008);
`else
    chk("score_after_4", score, 16'h0004);
`endif

    // randomized traffic, including steps while busy and in CHECK
    mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if (cake_valid && $urandom_range(0, 1) == 1) begin
          head_x = cake_x; head_y = cake_y;
        end else begin
          head_x = 12'($urandom_range(0, 700));
          head_y = 12'($urandom_range(0, 500));
        end
        step = 1'b1;
      end else begin
        step = 1'b0;
      end
      @(negedge clk);
    end
    step = 1'b0;

    // asynchronous reset in the middle of a regeneration
    mode = 0;
    do_eat();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_drive", drive, 1'b0);
    chk("mid_rst_valid", cake_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b1);
    chk("mid_rst_score", score, 16'h0000);
    chk("mid_rst_cake", {cake_x, cake_y}, 24'd0);
    box_hold_x = 12'd100; box_hold_y = 12'd200;
    @(negedge clk);
    rst_n = 1'b1;
    boot_check(12'd100, 12'd200);

    // bonus window: eat on the 5th step, then after 40 steps
`ifdef CAKE_BONUS_EN
    e1 = 16'h0002; e2 = 16'h0003;
`else
    e1 = 16'h0001; e2 = 16'h0002;
`endif
    for (int i = 0; i < 4; i++) do_step(12'd1, 12'd1);
    box_hold_x = 12'd300; box_hold_y = 12'd300;
    do_step(12'd100, 12'd200);
    chk("bonus_early", score, e1);
    wait_valid();
    for (int i = 0; i < 40; i++) do_step(12'd1, 12'd1);
    box_hold_x = 12'd100; box_hold_y = 12'd200;
    do_step(12'd300, 12'd300);
    chk("bonus_late", score, e2);

    // score carry and saturation
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 999; i++) do_eat();
`ifndef CAKE_BONUS_EN
    chk("score_0999", score, 16'h0999);
`endif
    do_eat();
`ifndef CAKE_BONUS_EN
    chk("score_1000", score, 16'h1000);
`endif
    for (int i = 0; i < 8999; i++) do_eat();
    chk("score_9999", score, 16'h9999);
    do_eat();
    chk("score_sat", score, 16'h9999);
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
